// File: rtl/sparse_mac_accumulator_if.sv
// sparse_mac_accumulator_if
//   Stream bundle between the sparse vector generator, the MAC accumulator
//   and the next layer.
//   in_valid/in_ready         : input beat handshake
//   in_activations            : one activation per output pixel, pixel j at [j*BIT_SIZE +: BIT_SIZE]
//   in_weights                : one weight per filter, filter 0 in the MSBs
//   out_valid/out_ready       : output feature-map handshake
//   out_data                  : requantised map, pixel j at [j*BIT_SIZE +: BIT_SIZE]
//   out_filter / out_last     : filter index of out_data / high for the final filter
//   modport master = upstream/downstream side, modport slave = accumulator side.
interface sparse_mac_accumulator_if #(
    parameter int OUT_PIX  = 4,
    parameter int FILTERS  = 2,
    parameter int BIT_SIZE = 16
);
    localparam int FCW = $clog2(FILTERS) + 1;

    logic                        in_valid;
    logic                        in_ready;
    logic [OUT_PIX*BIT_SIZE-1:0] in_activations;
    logic [FILTERS*BIT_SIZE-1:0] in_weights;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_PIX*BIT_SIZE-1:0] out_data;
    logic [FCW-1:0]              out_filter;
    logic                        out_last;

    modport master (
        output in_valid, in_activations, in_weights, out_ready,
        input  in_ready, out_valid, out_data, out_filter, out_last
    );

    modport slave (
        input  in_valid, in_activations, in_weights, out_ready,
        output in_ready, out_valid, out_data, out_filter, out_last
    );
endinterface

// File: rtl/sparse_mac_accumulator.sv
// sparse_mac_accumulator
//   Multiplies every (pixel, filter) pair of each input beat and accumulates
//   over NON_ZERO_WEIGHTS beats, then streams one requantised feature map per
//   filter (shift by FRAC_BITS, saturate to BIT_SIZE, optional ReLU).
//   Ports: clk, rst (synchronous, active high), bus (slave side of
//   sparse_mac_accumulator_if carrying both the input and output streams).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ACCUM | accepting beats (in_ready=1); beat 0 overwrites the accumulators
//   DRAIN | presenting one filter map per cycle (out_valid=1), in held off
module sparse_mac_accumulator #(
    parameter int IN_SIZE          = 4,
    parameter int KER_SIZE         = 3,
    parameter int STRIDE           = 1,
    parameter int PADDING          = 0,
    parameter int FILTERS          = 2,
    parameter int NON_ZERO_WEIGHTS = 6,
    parameter int BIT_SIZE         = 16,
    parameter int ACC_BIT_SIZE     = 40,
    parameter int FRAC_BITS        = 8,
    parameter int RELU             = 1
) (
    input  logic clk,
    input  logic rst,
    sparse_mac_accumulator_if.slave bus
);
    localparam int OUT_DIM = ((IN_SIZE - KER_SIZE + 2*PADDING) / STRIDE) + 1;
    localparam int OUT_PIX = OUT_DIM * OUT_DIM;
    localparam int FCW     = $clog2(FILTERS) + 1;
    localparam int FIW     = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam int BCW     = (NON_ZERO_WEIGHTS > 1) ? $clog2(NON_ZERO_WEIGHTS) : 1;
    localparam int EXT     = ACC_BIT_SIZE - BIT_SIZE;

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NON_ZERO_WEIGHTS - 1);
    localparam logic [FCW-1:0] LAST_FILT = FCW'(FILTERS - 1);

    localparam logic signed [ACC_BIT_SIZE-1:0] SAT_MAX = {{(EXT+1){1'b0}}, {(BIT_SIZE-1){1'b1}}};
    localparam logic signed [ACC_BIT_SIZE-1:0] SAT_MIN = {{(EXT+1){1'b1}}, {(BIT_SIZE-1){1'b0}}};
    localparam logic [BIT_SIZE-1:0] PIX_MAX = {1'b0, {(BIT_SIZE-1){1'b1}}};
    localparam logic [BIT_SIZE-1:0] PIX_MIN = {1'b1, {(BIT_SIZE-1){1'b0}}};

    if (ACC_BIT_SIZE < 2*BIT_SIZE + $clog2(NON_ZERO_WEIGHTS)) begin : g_acc_too_narrow
        $error("ACC_BIT_SIZE too small for NON_ZERO_WEIGHTS products");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;

    logic signed [ACC_BIT_SIZE-1:0] acc_q   [OUT_PIX][FILTERS];
    logic signed [ACC_BIT_SIZE-1:0] acc_d   [OUT_PIX][FILTERS];
    logic signed [ACC_BIT_SIZE-1:0] prod    [OUT_PIX][FILTERS];
    logic signed [ACC_BIT_SIZE-1:0] act_ext [OUT_PIX];
    logic signed [ACC_BIT_SIZE-1:0] wgt_ext [FILTERS];

    logic [FIW-1:0]              filt_idx;
    logic [OUT_PIX*BIT_SIZE-1:0] out_data_c;

    // Operands are sign-extended to the accumulator width first so the
    // product is formed at full precision without a separate widening step.
    always_comb begin
        for (int j = 0; j < OUT_PIX; j++) begin
            act_ext[j] = {{EXT{bus.in_activations[j*BIT_SIZE + BIT_SIZE - 1]}},
                          bus.in_activations[j*BIT_SIZE +: BIT_SIZE]};
        end
        for (int f = 0; f < FILTERS; f++) begin
            wgt_ext[f] = {{EXT{bus.in_weights[(FILTERS-f)*BIT_SIZE - 1]}},
                          bus.in_weights[(FILTERS-f)*BIT_SIZE - 1 -: BIT_SIZE]};
        end
        for (int j = 0; j < OUT_PIX; j++) begin
            for (int f = 0; f < FILTERS; f++) begin
                prod[j][f] = act_ext[j] * wgt_ext[f];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        filt_cnt_d = filt_cnt_q;
        acc_d      = acc_q;
        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    // Beat 0 overwrites, so no clear cycle is needed between tiles.
                    for (int j = 0; j < OUT_PIX; j++) begin
                        for (int f = 0; f < FILTERS; f++) begin
                            if (beat_cnt_q == '0) begin
                                acc_d[j][f] = prod[j][f];
                            end else begin
                                acc_d[j][f] = acc_q[j][f] + prod[j][f];
                            end
                        end
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (filt_cnt_q == LAST_FILT) begin
                        filt_cnt_d = '0;
                        state_d    = ACCUM;
                    end else begin
                        filt_cnt_d = filt_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            beat_cnt_q <= '0;
            filt_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // Accumulators carry no reset: the first beat of every tile overwrites them.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign filt_idx = filt_cnt_q[FIW-1:0];

    always_comb begin
        logic signed [ACC_BIT_SIZE-1:0] shifted;
        logic        [BIT_SIZE-1:0]     pix;
        out_data_c = '0;
        for (int j = 0; j < OUT_PIX; j++) begin
            shifted = acc_q[j][filt_idx] >>> FRAC_BITS;
            if (shifted > SAT_MAX) begin
                pix = PIX_MAX;
            end else if (shifted < SAT_MIN) begin
                pix = PIX_MIN;
            end else begin
                pix = shifted[BIT_SIZE-1:0];
            end
            if ((RELU != 0) && pix[BIT_SIZE-1]) begin
                pix = '0;
            end
            out_data_c[j*BIT_SIZE +: BIT_SIZE] = pix;
        end
    end

    assign bus.in_ready   = (state_q == ACCUM);
    assign bus.out_valid  = (state_q == DRAIN);
    assign bus.out_filter = filt_cnt_q;
    assign bus.out_last   = (state_q == DRAIN) && (filt_cnt_q == LAST_FILT);
    assign bus.out_data   = out_data_c;

endmodule

// File: tb/tb_sparse_mac_accumulator.sv
// tb_sparse_mac_accumulator
//   Drives two accumulator instances (RELU=1 and RELU=0) with identical
//   stimulus; expected maps are queued as tiles complete and popped when the
//   DUT hands an output beat over.
module tb_sparse_mac_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] act_bus;
    logic [31:0] w_bus;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] data_r;
        logic [63:0] data_l;
        int          filt;
        bit          last;
    } exp_t;

    exp_t   sb[$];
    longint sum_m [4][2];
    int     tb_beat = 0;

    always #5 clk = ~clk;

    sparse_mac_accumulator_if #(.OUT_PIX(4), .FILTERS(2), .BIT_SIZE(16)) bus_r ();
    sparse_mac_accumulator_if #(.OUT_PIX(4), .FILTERS(2), .BIT_SIZE(16)) bus_l ();

    assign bus_r.in_valid       = in_valid;
    assign bus_r.in_activations = act_bus;
    assign bus_r.in_weights     = w_bus;
    assign bus_r.out_ready      = out_ready;
    assign bus_l.in_valid       = in_valid;
    assign bus_l.in_activations = act_bus;
    assign bus_l.in_weights     = w_bus;
    assign bus_l.out_ready      = out_ready;

    sparse_mac_accumulator #(.RELU(1)) u_dut_relu (.clk(clk), .rst(rst), .bus(bus_r));
    sparse_mac_accumulator #(.RELU(0)) u_dut_lin  (.clk(clk), .rst(rst), .bus(bus_l));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] requant(input longint s, input bit relu);
        longint sh;
        sh = s >>> 8;
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
        if (relu && sh < 0) sh = 0;
        return 16'(sh);
    endfunction

    function automatic logic [63:0] pack_a(input logic [15:0] a0, input logic [15:0] a1,
                                           input logic [15:0] a2, input logic [15:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic send_beat(input logic [63:0] acts, input logic [31:0] ws, input int bubbles);
        int n;
        logic signed [15:0] a;
        logic signed [15:0] w;
        exp_t e;
        if (bubbles > 0) begin
            in_valid = 1'b0;
            repeat (bubbles) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        act_bus  = acts;
        w_bus    = ws;
        n = 0;
        while (!bus_r.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", bus_r.in_ready, 1);
        for (int j = 0; j < 4; j++) begin
            for (int f = 0; f < 2; f++) begin
                a = acts[j*16 +: 16];
                w = ws[(2-f)*16-1 -: 16];
                sum_m[j][f] = ((tb_beat == 0) ? 64'sd0 : sum_m[j][f]) + longint'(a) * longint'(w);
            end
        end
        tb_beat++;
        if (tb_beat == 6) begin
            tb_beat = 0;
            for (int f = 0; f < 2; f++) begin
                for (int j = 0; j < 4; j++) begin
                    e.data_r[j*16 +: 16] = requant(sum_m[j][f], 1'b1);
                    e.data_l[j*16 +: 16] = requant(sum_m[j][f], 1'b0);
                end
                e.filt = f;
                e.last = (f == 1);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_tile(input logic [63:0] acts, input logic [31:0] ws, input int bubbles);
        for (int b = 0; b < 6; b++) send_beat(acts, ws, bubbles);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !bus_r.in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 0);
        chk("drain_ready", bus_r.in_ready, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_r.out_valid && out_ready) begin
            chk("excl_ready", bus_r.in_ready, 0);
            chk("lin_valid", bus_l.out_valid, 1);
            if (sb.size() == 0) begin
                chk("unexpected_out", bus_r.out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("data_relu", bus_r.out_data, e.data_r);
                chk("data_lin", bus_l.out_data, e.data_l);
                chk("filter", 64'(bus_r.out_filter), 64'(e.filt));
                chk("last", bus_r.out_last, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        logic [63:0] act_one, act_max, act_mix, act_rnd;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        act_bus   = '0;
        w_bus     = '0;
        act_one   = pack_a(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        act_max   = pack_a(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        act_mix   = pack_a(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", bus_r.in_ready, 1);
        chk("rst_out_valid", bus_r.out_valid, 0);
        chk("rst_out_last", bus_r.out_last, 0);
        chk("rst_out_filter", 64'(bus_r.out_filter), 0);

        // all-ones tile, latency of out_valid
        send_tile(act_one, {16'h0100, 16'h0100}, 0);
        @(negedge clk);
        chk("lat1_valid", bus_r.out_valid, 1);
        chk("lat1_in_ready", bus_r.in_ready, 0);
        chk("lat1_pix", bus_r.out_data, {4{16'h0600}});
        wait_drain();

        // saturation, both signs
        send_tile(act_max, {16'h7FFF, 16'h7FFF}, 0);
        wait_drain();
        send_tile(act_max, {16'h8001, 16'h8001}, 0);
        wait_drain();
        send_tile(act_max, {16'h7FFF, 16'h8001}, 0);
        wait_drain();

        // mixed signs: w0 = +1.0, w1 = -0.5
        send_tile(act_mix, {16'h0100, 16'hFF80}, 0);
        wait_drain();

        // downstream stall with in_valid held high
        out_ready = 1'b0;
        send_tile(act_mix, {16'h0200, 16'hFF00}, 0);
        e = sb[0];
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            act_bus  = {$urandom(), $urandom()};
            w_bus    = $urandom();
            @(negedge clk);
            chk("stall_valid", bus_r.out_valid, 1);
            chk("stall_in_ready", bus_r.in_ready, 0);
            chk("stall_filter", 64'(bus_r.out_filter), 0);
            chk("stall_data_relu", bus_r.out_data, e.data_r);
            chk("stall_data_lin", bus_l.out_data, e.data_l);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // bubbles between beats
        for (int b = 0; b < 6; b++) send_beat(act_one, {16'h0100, 16'h0100}, (b % 2 == 0) ? 0 : 2);
        wait_drain();

        // reset after three beats discards the partial tile
        for (int b = 0; b < 3; b++) send_beat(act_max, {16'h7FFF, 16'h8001}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        tb_beat = 0;
        @(negedge clk);
        chk("mrst_in_ready", bus_r.in_ready, 1);
        chk("mrst_out_valid", bus_r.out_valid, 0);
        chk("mrst_out_last", bus_r.out_last, 0);
        chk("mrst_out_filter", 64'(bus_r.out_filter), 0);
        chk("mrst_pending", 64'(sb.size()), 0);

        // fresh tile, then a second tile held at the input during drain
        send_tile(act_one, {16'h0100, 16'h0100}, 0);
        in_valid = 1'b1;
        act_bus  = act_mix;
        w_bus    = {16'h0100, 16'hFF80};
        n = 0;
        @(negedge clk);
        while (!(bus_r.out_valid && bus_r.out_last) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_last", bus_r.out_last, 1);
        @(negedge clk);
        chk("b2b_ready", bus_r.in_ready, 1);
        send_tile(act_mix, {16'h0100, 16'hFF80}, 0);
        wait_drain();

        // random full-range tiles
        for (int t = 0; t < 3; t++) begin
            for (int b = 0; b < 6; b++) begin
                act_rnd = {$urandom(), $urandom()};
                send_beat(act_rnd, $urandom(), $urandom_range(0, 1));
            end
            wait_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
